// File: rtl/obs_lane_requant.sv
// obs_lane_requant: per-frame multi-lane requantiser for the accelerator output path.
// Each wide signed input lane is arithmetic-right-shifted, optionally rounded
// half-up and optionally saturated into a narrow signed output lane. The
// configuration (shift/round/sat) is taken from a side AXI4-Stream port and only
// changes between frames.
//
// Ports:
//   aclk, aresetn                  clock, asynchronous active-low reset
//   s_cfg_tvalid/tready/tdata      config beat: [SHIFT_W-1:0] shift, [6] round_en, [7] sat_en
//   s_axis_tvalid/tready/tdata     input beats, lane i at [i*IN_LANE_W +: IN_LANE_W]
//   s_axis_tuser, s_axis_tlast     sideband, travels with the beat
//   m_axis_tvalid/tready/tdata     output beats, lane i at [i*OUT_SLOT_W +: OUT_LANE_W]
//   m_axis_tuser, m_axis_tlast     registered sideband
//   sat_clr                        synchronous clear of sat_flag
//   sat_flag                       sticky saturation indicator
module obs_lane_requant #(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned IN_LANE_W     = 40,
    parameter int unsigned OUT_LANE_W    = 16,
    parameter int unsigned OUT_SLOT_W    = 32,
    parameter int unsigned SHIFT_W       = 5,
    parameter int unsigned DEFAULT_SHIFT = 7
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             s_cfg_tvalid,
    output logic                             s_cfg_tready,
    input  logic [7:0]                       s_cfg_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [NUM_LANES*IN_LANE_W-1:0]   s_axis_tdata,
    input  logic                             s_axis_tuser,
    input  logic                             s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [NUM_LANES*OUT_SLOT_W-1:0]  m_axis_tdata,
    output logic                             m_axis_tuser,
    output logic                             m_axis_tlast,
    input  logic                             sat_clr,
    output logic                             sat_flag
);

    localparam int unsigned MAX_SHIFT = IN_LANE_W - OUT_LANE_W;
    localparam int unsigned EXT_W     = IN_LANE_W + 1;
    localparam int unsigned OUT_W     = NUM_LANES * OUT_SLOT_W;

    // Saturation bounds held at the extended width so comparisons stay signed.
    localparam logic signed [EXT_W-1:0] SAT_MAX =
        EXT_W'((64'(1) << (OUT_LANE_W - 1)) - 64'(1));
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   run_q;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic                   round_q, round_d;
    logic                   sat_en_q, sat_en_d;
    logic                   m_valid_q, m_valid_d;
    logic [OUT_W-1:0]       m_data_q, m_data_d;
    logic                   m_user_q, m_user_d;
    logic                   m_last_q, m_last_d;
    logic                   sat_flag_q, sat_flag_d;

    logic                   cfg_acc_c;
    logic                   dat_acc_c;
    logic [SHIFT_W-1:0]     shift_eff_c;
    logic [OUT_LANE_W:0]    lane_res_c;
    logic [OUT_W-1:0]       lanes_out_c;
    logic                   any_sat_c;

    // Bits of the config byte between the shift field and round_en carry no meaning.
    if (SHIFT_W < 6) begin : g_cfg_spare
        logic cfg_unused_c;
        assign cfg_unused_c = ^s_cfg_tdata[5:SHIFT_W];
    end

    // One lane: returns {saturated, narrow result}.
    function automatic logic [OUT_LANE_W:0] requant_lane(
        input logic [IN_LANE_W-1:0] x,
        input logic [SHIFT_W-1:0]   s,
        input logic                 rnd,
        input logic                 sat
    );
        logic signed [EXT_W-1:0] xe;
        logic signed [EXT_W-1:0] r;
        logic signed [EXT_W-1:0] y;
        logic [OUT_LANE_W:0]     res;
        xe = {x[IN_LANE_W-1], x};
        r  = '0;
        if (rnd && (s != '0)) begin
            r = EXT_W'(1) << (s - SHIFT_W'(1));
        end
        // One guard bit means x + r cannot overflow before the shift.
        y = (xe + r) >>> s;
        if (sat && (y > SAT_MAX)) begin
            res = {1'b1, SAT_MAX[OUT_LANE_W-1:0]};
        end else if (sat && (y < SAT_MIN)) begin
            res = {1'b1, SAT_MIN[OUT_LANE_W-1:0]};
        end else begin
            res = {1'b0, y[OUT_LANE_W-1:0]};
        end
        return res;
    endfunction

    // Handshakes: config has priority over data while between frames.
    assign s_cfg_tready  = run_q & (state_q == ST_IDLE);
    assign s_axis_tready = run_q & (~m_valid_q | m_axis_tready)
                         & ~((state_q == ST_IDLE) & s_cfg_tvalid);
    assign cfg_acc_c     = s_cfg_tvalid & s_cfg_tready;
    assign dat_acc_c     = s_axis_tvalid & s_axis_tready;

    // Oversized shifts fall back to the largest shift that still fits the output.
    assign shift_eff_c = (32'(shift_q) > MAX_SHIFT) ? SHIFT_W'(MAX_SHIFT) : shift_q;

    // Lane datapath; unused slot bits stay zero.
    always_comb begin
        lanes_out_c = '0;
        any_sat_c   = 1'b0;
        lane_res_c  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_res_c = requant_lane(s_axis_tdata[i*IN_LANE_W +: IN_LANE_W],
                                      shift_eff_c, round_q, sat_en_q);
            lanes_out_c[i*OUT_SLOT_W +: OUT_LANE_W] = lane_res_c[OUT_LANE_W-1:0];
            any_sat_c = any_sat_c | lane_res_c[OUT_LANE_W];
        end
    end

    // Frame FSM, config register, output register and sticky flag next-state.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        round_d    = round_q;
        sat_en_d   = sat_en_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_user_d   = m_user_q;
        m_last_d   = m_last_q;
        sat_flag_d = sat_flag_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dat_acc_c && !s_axis_tlast) begin
                    state_d = ST_IN_FRAME;
                end
            end
            ST_IN_FRAME: begin
                if (dat_acc_c && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_acc_c) begin
            shift_d  = s_cfg_tdata[SHIFT_W-1:0];
            round_d  = s_cfg_tdata[6];
            sat_en_d = s_cfg_tdata[7];
        end

        if (dat_acc_c) begin
            m_valid_d = 1'b1;
            m_data_d  = lanes_out_c;
            m_user_d  = s_axis_tuser;
            m_last_d  = s_axis_tlast;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        // A new saturation event beats a simultaneous clear.
        if (dat_acc_c && any_sat_c) begin
            sat_flag_d = 1'b1;
        end else if (sat_clr) begin
            sat_flag_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            shift_q    <= SHIFT_W'(DEFAULT_SHIFT);
            round_q    <= 1'b0;
            sat_en_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_user_q   <= 1'b0;
            m_last_q   <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            shift_q    <= shift_d;
            round_q    <= round_d;
            sat_en_q   <= sat_en_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_user_q   <= m_user_d;
            m_last_q   <= m_last_d;
            sat_flag_q <= sat_flag_d;
        end
    end

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tuser  = m_user_q;
    assign m_axis_tlast  = m_last_q;
    assign sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_obs_lane_requant.sv
// Bench for obs_lane_requant: directed literal checks plus randomized frames
// compared every cycle against a behavioural model of the requantiser.
module tb_obs_lane_requant;

    localparam int unsigned NL  = 4;
    localparam int unsigned IW  = 40;
    localparam int unsigned OW  = 16;
    localparam int unsigned SW  = 32;
    localparam int unsigned SHW = 5;
    localparam int unsigned DW  = NL * IW;
    localparam int unsigned MW  = NL * SW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_cfg_tvalid = 1'b0;
    logic          s_cfg_tready;
    logic [7:0]    s_cfg_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [MW-1:0] m_axis_tdata;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          sat_clr = 1'b0;
    logic          sat_flag;

    always #5 aclk = ~aclk;

    obs_lane_requant #(
        .NUM_LANES(NL), .IN_LANE_W(IW), .OUT_LANE_W(OW), .OUT_SLOT_W(SW),
        .SHIFT_W(SHW), .DEFAULT_SHIFT(7)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready), .s_cfg_tdata(s_cfg_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .sat_clr(sat_clr), .sat_flag(sat_flag)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [MW-1:0] data;
        logic          user;
        logic          last;
    } beat_t;

    beat_t          exp_q[$];
    logic [SHW-1:0] m_shift   = SHW'(7);
    logic           m_rnd     = 1'b0;
    logic           m_sat     = 1'b0;
    logic           m_flag    = 1'b0;
    logic           m_run     = 1'b0;
    logic           m_inframe = 1'b0;
    logic           mc_acc, md_acc, mev;
    logic [MW-1:0]  mo;

    function automatic logic cfg_rdy_m();
        return m_run && !m_inframe;
    endfunction

    function automatic logic dat_rdy_m();
        return m_run && (exp_q.size() == 0 || m_axis_tready) && !(!m_inframe && s_cfg_tvalid);
    endfunction

    // Requantise one beat with the model's active config using plain integer math.
    function automatic void model_beat(input logic [DW-1:0] d, output logic [MW-1:0] o,
                                       output logic ev);
        longint x, r, y, mx, mn;
        int s;
        logic signed [IW-1:0] lane_v;
        o  = '0;
        ev = 1'b0;
        s  = int'(m_shift);
        if (s > int'(IW - OW)) s = int'(IW - OW);
        mx = (longint'(1) <<< (OW - 1)) - 1;
        mn = -mx - 1;
        for (int i = 0; i < NL; i++) begin
            lane_v = d[i*IW +: IW];
            x = lane_v;
            r = (m_rnd && s > 0) ? (longint'(1) <<< (s - 1)) : 0;
            y = (x + r) >>> s;
            if (m_sat && y > mx) begin
                y = mx; ev = 1'b1;
            end else if (m_sat && y < mn) begin
                y = mn; ev = 1'b1;
            end
            o[i*SW +: OW] = OW'(y);
        end
    endfunction

    initial begin
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                exp_q.delete();
                m_run = 1'b0; m_inframe = 1'b0;
                m_shift = SHW'(7); m_rnd = 1'b0; m_sat = 1'b0; m_flag = 1'b0;
            end else begin
                mc_acc = s_cfg_tvalid && cfg_rdy_m();
                md_acc = s_axis_tvalid && dat_rdy_m();
                mev    = 1'b0;
                if (exp_q.size() > 0 && m_axis_tready) void'(exp_q.pop_front());
                if (md_acc) begin
                    model_beat(s_axis_tdata, mo, mev);
                    exp_q.push_back('{data: mo, user: s_axis_tuser, last: s_axis_tlast});
                    m_inframe = !s_axis_tlast;
                end
                if (mev) m_flag = 1'b1;
                else if (sat_clr) m_flag = 1'b0;
                if (mc_acc) begin
                    m_shift = s_cfg_tdata[SHW-1:0];
                    m_rnd   = s_cfg_tdata[6];
                    m_sat   = s_cfg_tdata[7];
                end
                m_run = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge aclk);
            chk("s_cfg_tready", s_cfg_tready, cfg_rdy_m());
            chk("s_axis_tready", s_axis_tready, dat_rdy_m());
            chk("m_axis_tvalid", m_axis_tvalid, exp_q.size() != 0);
            chk("sat_flag", sat_flag, m_flag);
            if (exp_q.size() != 0 && m_axis_tvalid) begin
                chk("m_axis_tdata", m_axis_tdata, exp_q[0].data);
                chk("m_axis_tuser", m_axis_tuser, exp_q[0].user);
                chk("m_axis_tlast", m_axis_tlast, exp_q[0].last);
            end
        end
    end

    // Output beat counter for the long backpressured frame.
    logic cnt_en = 1'b0;
    int   out_cnt = 0, last_cnt = 0, last_idx = 0;
    initial begin
        forever begin
            @(posedge aclk);
            if (cnt_en && aresetn && m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                if (m_axis_tlast) begin
                    last_cnt++;
                    last_idx = out_cnt;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] rep(input logic [IW-1:0] v);
        logic [DW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*IW +: IW] = v;
        return d;
    endfunction

    function automatic logic [MW-1:0] orep(input logic [OW-1:0] v);
        logic [MW-1:0] d;
        d = '0;
        for (int i = 0; i < NL; i++) d[i*SW +: OW] = v;
        return d;
    endfunction

    function automatic logic [IW-1:0] rand_lane();
        logic [63:0] w;
        w = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return w[IW-1:0];
            1: return IW'(signed'(w[19:0]));
            2: return IW'(signed'(w[29:0]));
            default: return w[0] ? 40'h7F_FFFF_FFFF : 40'h80_0000_0000;
        endcase
    endfunction

    task automatic send_cfg(input logic [7:0] d);
        int n;
        s_cfg_tdata  = d;
        s_cfg_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_cfg_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        chk("cfg accepted", s_cfg_tready, 1'b1);
        @(posedge aclk);
        #1 s_cfg_tvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, input int gap);
        int n;
        repeat (gap) begin
            @(posedge aclk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!s_axis_tready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        chk("beat accepted", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
    endtask

    // Called just after the accepting edge: output must already be valid.
    task automatic expect_out(input string name, input logic [MW-1:0] exp);
        chk({name, " valid"}, m_axis_tvalid, 1'b1);
        chk(name, m_axis_tdata, exp);
    endtask

    logic bp_done;

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and release.
        repeat (3) @(posedge aclk);
        #1;
        chk("rst s_cfg_tready", s_cfg_tready, 1'b0);
        chk("rst s_axis_tready", s_axis_tready, 1'b0);
        chk("rst m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk("rst m_axis_tdata", m_axis_tdata, '0);
        chk("rst sat_flag", sat_flag, 1'b0);
        #2 aresetn = 1'b1;
        #1;
        chk("post-release cfg_tready", s_cfg_tready, 1'b0);
        chk("post-release axis_tready", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        chk("run cfg_tready", s_cfg_tready, 1'b1);
        chk("run axis_tready", s_axis_tready, 1'b1);

        // Default config.
        send_beat({40'hFF_FFFF_FF80, 40'hFF_FFFF_FF80, 40'hFF_FFFF_FF80, 40'h00_0012_3480},
                  1'b1, 1'b1, 0);
        expect_out("default shift",
                   {32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_2469});
        chk("default tuser", m_axis_tuser, 1'b1);
        chk("default tlast", m_axis_tlast, 1'b1);

        // Rounding.
        send_cfg(8'h47);
        send_beat(rep(40'h40), 1'b0, 1'b1, 0);
        expect_out("round on", orep(16'h0001));
        send_cfg(8'h07);
        send_beat(rep(40'h40), 1'b0, 1'b1, 0);
        expect_out("round off", orep(16'h0000));

        // Saturation and sticky flag.
        send_cfg(8'h85);
        send_beat(rep(40'h00_4000_0000), 1'b0, 1'b1, 0);
        expect_out("sat pos", orep(16'h7FFF));
        chk("sat_flag set", sat_flag, 1'b1);
        send_beat(rep(40'hFF_C000_0000), 1'b0, 1'b1, 0);
        expect_out("sat neg", orep(16'h8000));
        send_cfg(8'h05);
        send_beat(rep(40'h00_4000_0000), 1'b0, 1'b1, 0);
        expect_out("wrap no sat", orep(16'h0000));
        chk("sat_flag held", sat_flag, 1'b1);
        sat_clr = 1'b1;
        @(posedge aclk);
        #1 sat_clr = 1'b0;
        chk("sat_flag cleared", sat_flag, 1'b0);

        // Shift clamp and zero shift with rounding requested.
        send_cfg(8'h1F);
        send_beat(rep(40'h12_3456_7800), 1'b0, 1'b1, 0);
        expect_out("shift clamp", orep(16'h1234));
        send_cfg(8'h40);
        send_beat(rep(40'h00_0001_2345), 1'b0, 1'b1, 0);
        expect_out("shift zero", orep(16'h2345));

        // Config held off mid-frame.
        send_cfg(8'h07);
        send_beat(rep(40'h100), 1'b0, 1'b0, 0);
        s_cfg_tdata  = 8'h48;
        s_cfg_tvalid = 1'b1;
        @(negedge aclk);
        chk("cfg held mid-frame", s_cfg_tready, 1'b0);
        @(posedge aclk);
        #1;
        send_beat(rep(40'h200), 1'b0, 1'b1, 0);
        expect_out("old cfg end of frame", orep(16'h0004));
        send_cfg(8'h48);
        send_beat(rep(40'h180), 1'b0, 1'b1, 0);
        expect_out("new cfg after frame", orep(16'h0002));

        // Simultaneous config and data in IDLE.
        s_cfg_tdata   = 8'h04;
        s_cfg_tvalid  = 1'b1;
        s_axis_tdata  = rep(40'h100);
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        chk("simul data stalled", s_axis_tready, 1'b0);
        chk("simul cfg ready", s_cfg_tready, 1'b1);
        @(posedge aclk);
        #1 s_cfg_tvalid = 1'b0;
        @(negedge aclk);
        chk("simul data ready", s_axis_tready, 1'b1);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
        expect_out("simul new shift", orep(16'h0010));

        // Randomized frames under random backpressure; the last one is 64 beats.
        for (int f = 0; f < 4; f++) begin
            int len;
            len = (f == 3) ? 64 : int'($urandom_range(1, 10));
            repeat (3) @(posedge aclk);
            #1;
            send_cfg(8'($urandom_range(0, 255)));
            out_cnt = 0; last_cnt = 0; last_idx = 0;
            cnt_en  = 1'b1;
            bp_done = 1'b0;
            fork
                begin
                    for (int b = 0; b < len; b++) begin
                        logic [DW-1:0] d;
                        for (int i = 0; i < NL; i++) d[i*IW +: IW] = rand_lane();
                        send_beat(d, 1'($urandom_range(0, 1)), b == len - 1,
                                  int'($urandom_range(0, 1)));
                    end
                    bp_done = 1'b1;
                end
                begin
                    while (!bp_done) begin
                        @(posedge aclk);
                        #1;
                        m_axis_tready = 1'($urandom_range(0, 1));
                        sat_clr       = ($urandom_range(0, 7) == 0);
                    end
                end
            join
            m_axis_tready = 1'b1;
            sat_clr       = 1'b0;
            repeat (3) @(posedge aclk);
            #1;
            cnt_en = 1'b0;
            chk("frame beat count", 32'(out_cnt), 32'(len));
            chk("frame tlast count", 32'(last_cnt), 32'd1);
            chk("frame tlast position", 32'(last_idx), 32'(len));
        end

        // Reset mid-frame while a beat sits in the output register.
        send_cfg(8'h84);
        m_axis_tready = 1'b0;
        send_beat(rep(40'h00_007F_FFFF), 1'b0, 1'b0, 0);
        chk("pre-reset sat_flag", sat_flag, 1'b1);
        @(negedge aclk);
        chk("held valid", m_axis_tvalid, 1'b1);
        chk("held stall", s_axis_tready, 1'b0);
        chk("held data", m_axis_tdata, orep(16'h7FFF));
        #2 aresetn = 1'b0;
        #1;
        chk("midrst m_axis_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst sat_flag", sat_flag, 1'b0);
        chk("midrst s_cfg_tready", s_cfg_tready, 1'b0);
        chk("midrst s_axis_tready", s_axis_tready, 1'b0);
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        #1;
        chk("rerelease cfg_tready", s_cfg_tready, 1'b0);
        chk("rerelease axis_tready", s_axis_tready, 1'b0);
        @(posedge aclk);
        #1;
        chk("rerun cfg_tready", s_cfg_tready, 1'b1);
        chk("rerun axis_tready", s_axis_tready, 1'b1);
        send_beat(rep(40'h80), 1'b1, 1'b1, 0);
        expect_out("default cfg after reset", orep(16'h0001));

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/obs_lane_requant.md
# obs_lane_requant

Parametrised per-frame lane requantiser for the accelerator output path. It takes a packed multi-lane stream of wide signed accumulator lanes and reduces each lane to a narrow output lane. The reduction uses an arithmetic right shift, optional round-half-up and optional saturation, all selected per frame by a configuration word on a separate AXI4-Stream port. It sits between the compute core and the output DMA, and it generalises the fixed 4-lane, 40-to-16-bit, shift-5..8 selector to arbitrary lane geometry.

## Interface
- NUM_LANES, 4, number of packed lanes per beat
- IN_LANE_W, 40, signed input lane width
- OUT_LANE_W, 16, signed output lane width (must be < IN_LANE_W)
- OUT_SLOT_W, 32, output slot pitch per lane (must be ≥ OUT_LANE_W)
- SHIFT_W, 5, width of the shift field
- DEFAULT_SHIFT, 7, shift value in use after reset
- aclk  in  1  sole clock, all logic rising-edge
- aresetn  in  1  asynchronous active-low reset
- s_cfg_tvalid / s_cfg_tready  in/out  1  config handshake
- s_cfg_tdata  in  8  [SHIFT_W-1:0] shift, [6] round_en, [7] sat_en
- s_axis_tvalid / s_axis_tready  in/out  1  data input handshake
- s_axis_tdata  in  NUM_LANES*IN_LANE_W  lane i at [i*IN_LANE_W +: IN_LANE_W]
- s_axis_tuser, s_axis_tlast  in  1  passed through with data
- m_axis_tvalid / m_axis_tready  out/in  1  output handshake
- m_axis_tdata  out  NUM_LANES*OUT_SLOT_W  lane i at [i*OUT_SLOT_W +: OUT_LANE_W], remaining slot bits 0
- m_axis_tuser, m_axis_tlast  out  1  registered copies
- sat_clr  in  1  synchronous pulse, clears sat_flag
- sat_flag  out  1  sticky, set when any lane saturated

## Operation
- Active config (shift, round_en, sat_en) is register-held. Reset value: DEFAULT_SHIFT, 0, 0.
- Shift is clamped: values above IN_LANE_W-OUT_LANE_W are applied as IN_LANE_W-OUT_LANE_W.
- Frame FSM has two states:
  - IDLE (reset state): s_cfg_tready = run.
  - IN_FRAME: s_cfg_tready = 0.
- IDLE → IN_FRAME on an accepted data beat with tlast=0.
- IN_FRAME → IDLE on an accepted data beat with tlast=1.
- An accepted tlast=1 beat in IDLE stays in IDLE (single-beat frame).
- Config accept (s_cfg_tvalid & s_cfg_tready) updates the active config at that clock edge. The new config applies to the next accepted data beat.
- s_axis_tready = run & (~m_axis_tvalid | m_axis_tready) & ~(state==IDLE & s_cfg_tvalid). When config and data are both valid in IDLE, config wins and data stalls one cycle.
- run: a register cleared by reset and set on the first aclk edge after deassertion.
- Per-lane arithmetic on x (signed IN_LANE_W) with shift s:
  - r = 2^(s-1) if round_en and s>0, else 0.
  - y = (x + r) >>> s, computed in IN_LANE_W+1 bits (no overflow on rounding).
  - If sat_en and y > 2^(OUT_LANE_W-1)-1 → output max positive (0x7FFF). If y < -2^(OUT_LANE_W-1) → output min negative (0x8000). Either case sets sat_flag.
  - Otherwise the output is y[OUT_LANE_W-1:0] (wrap).
- sat_flag priority: a saturation event in the same cycle as sat_clr wins (flag stays 1).
- tuser/tlast are registered alongside tdata unchanged.

## Timing
- Latency: 1 cycle, from accepted input beat to m_axis_tvalid.
- Output register: full throughput (1 beat/cycle) under m_axis_tready=1.
- While m_axis_tvalid=1 & m_axis_tready=0: m_axis_tdata/tuser/tlast remain stable and s_axis_tready=0.
- Reset (async assert) state:
  - m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, sat_flag = 0.
  - s_cfg_tready, s_axis_tready = 0.
  - FSM = IDLE, config = defaults.
- Both readies stay 0 until the first edge after deassertion.
- Reset mid-frame: the partial frame is discarded, the output beat is dropped, and the config reverts to defaults.

## Test plan
- Default config, no cfg beat. Lane0 = 40'h00_0012_3480, lanes 1-3 = 40'hFF_FFFF_FF80 → lane0 out 16'h2469; lanes 1-3 out 16'hFFFF; upper slot bits 0; valid one cycle after accept.
- Rounding. cfg = shift 7, round_en → lane 40'h40 out 16'h0001. Same lane with round_en=0 → 16'h0000.
- Saturation. cfg = shift 5, sat_en, lane 40'h00_4000_0000 → out 16'h7FFF, sat_flag=1. Negative counterpart → 16'h8000. With sat_en=0 → 16'h0000, sat_flag unchanged. sat_clr → flag 0.
- Cfg/frame ordering:
  - cfg presented mid-frame is held off (s_cfg_tready=0) until the tlast beat is accepted.
  - Simultaneous cfg+data in IDLE: cfg accepted first, data taken next cycle with the new shift.
- Backpressure: random m_axis_tready over a 64-beat frame → output sequence identical to input order, no loss or duplication, tlast on beat 64 only.
- Reset asserted mid-frame with a beat held in the output register → m_axis_tvalid drops immediately. After release, config is the default and readies return after one cycle.
